// File: rtl/pipe_result_buffer.sv
// Result buffer between a pipeline and a reader. It holds up to DEPTH words in
// write order, gives a registered read with one cycle of latency, and keeps
// sticky overflow and underflow flags plus a running sum of accepted words.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   in_valid, in_data   result word from the producer
//   rd_req              request to pop the oldest stored word
//   rd_data, rd_valid   popped word, valid for one cycle after an accepted read
//   full, empty, count  occupancy (full and empty are decoded from count)
//   overflow            sticky: a word arrived while full and was dropped
//   underflow           sticky: rd_req arrived while empty
//   sum                 sum of all accepted words, modulo 2^WIDTH
module pipe_result_buffer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             rd_req,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow,
    output logic [WIDTH-1:0] sum
);

    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,    rd_ptr_d;
    logic [CW-1:0]    count_q,     count_d;
    logic             rd_valid_q,  rd_valid_d;
    logic [WIDTH-1:0] rd_data_q,   rd_data_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             overflow_q,  overflow_d;
    logic             underflow_q, underflow_d;

    logic full_c;
    logic empty_c;
    logic wr_ok_c;
    logic rd_ok_c;

    // Occupancy decode from the registered count.
    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == '0);

    // A write is taken while full only if a read frees the oldest slot in the
    // same cycle; a read is never satisfied from the incoming word.
    assign wr_ok_c = in_valid && (!full_c || rd_req);
    assign rd_ok_c = rd_req && !empty_c;

    // Next-state logic for pointers, count, read port, sum and flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        sum_d       = sum_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_ok_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            sum_d    = sum_q + in_data;
        end

        if (rd_ok_c) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end

        case ({wr_ok_c, rd_ok_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (in_valid && full_c && !rd_req) begin
            overflow_d = 1'b1;
        end
        if (rd_req && empty_c) begin
            underflow_d = 1'b1;
        end
    end

    // Control and datapath registers; reset wins over any concurrent request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            sum_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            sum_q       <= sum_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not cleared; stale entries are unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok_c) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign full      = full_c;
    assign empty     = empty_c;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign sum       = sum_q;

endmodule

// File: tb/tb_pipe_result_buffer.sv
// Directed bench for pipe_result_buffer (WIDTH=32, DEPTH=8): a vector table of
// single-cycle stimulus with hand-computed expected outputs, followed by a
// hand-written interleaved sequence that wraps the pointers several times.
module tb_pipe_result_buffer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        rd_req;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;
    logic [31:0] sum;

    pipe_result_buffer #(.WIDTH(32), .DEPTH(8), .AW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .sum       (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        in_valid;
        logic [31:0] in_data;
        logic        rd_req;
        logic        exp_rv;
        logic [31:0] exp_rd;
        logic [3:0]  exp_cnt;
        logic [31:0] exp_sum;
        logic        exp_ovf;
        logic        exp_unf;
    } vec_t;

    vec_t vecs[$];
    int   n_pass;
    int   n_total;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    endtask

    task automatic v(input logic r, input logic iv, input logic [31:0] d, input logic rr,
                     input logic erv, input logic [31:0] erd, input logic [3:0] ecnt,
                     input logic [31:0] esum, input logic eo, input logic eu);
        vec_t t;
        t.rst_n = r; t.in_valid = iv; t.in_data = d; t.rd_req = rr;
        t.exp_rv = erv; t.exp_rd = erd; t.exp_cnt = ecnt; t.exp_sum = esum;
        t.exp_ovf = eo; t.exp_unf = eu;
        vecs.push_back(t);
    endtask

    // Drive away from the active edge, then sample 1 time unit after it.
    task automatic drive_step(input logic r, input logic iv, input logic [31:0] d,
                              input logic rr);
        @(negedge clk);
        rst_n = r; in_valid = iv; in_data = d; rd_req = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int idx, input logic erv, input logic [31:0] erd,
                             input logic [3:0] ecnt, input logic [31:0] esum,
                             input logic eo, input logic eu);
        check("rd_valid",  idx, 32'(rd_valid),  32'(erv));
        check("rd_data",   idx, rd_data,        erd);
        check("count",     idx, 32'(count),     32'(ecnt));
        check("sum",       idx, sum,            esum);
        check("overflow",  idx, 32'(overflow),  32'(eo));
        check("underflow", idx, 32'(underflow), 32'(eu));
        check("full",      idx, 32'(full),      32'(ecnt == 4'd8));
        check("empty",     idx, 32'(empty),     32'(ecnt == 4'd0));
    endtask

    initial begin
        logic [31:0] model_q[$];
        logic [31:0] exp_sum;
        logic [31:0] last_rd;
        logic        exp_rv;
        logic        rr;

        n_pass = 0; n_total = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; rd_req = 1'b0;

        // Two results of 6, then two reads.
        v(0,0,0,0, 0,0,0,0,0,0);
        v(1,1,6,0, 0,0,1,6,0,0);
        v(1,1,6,0, 0,0,2,12,0,0);
        v(1,0,0,1, 1,6,1,12,0,0);
        v(1,0,0,1, 1,6,0,12,0,0);
        v(1,0,0,0, 0,6,0,12,0,0);

        // Fill, overflow on a lone write, drain in order.
        v(0,0,0,0, 0,0,0,0,0,0);
        for (int i = 1; i <= 8; i++) v(1,1,32'(i),0, 0,0,4'(i),32'(i*(i+1)/2),0,0);
        v(1,1,9,0, 0,0,8,36,1,0);
        for (int i = 1; i <= 8; i++) v(1,0,0,1, 1,32'(i),4'(8-i),36,1,0);

        // Full with simultaneous write and read, then drain and read empty.
        v(0,0,0,0, 0,0,0,0,0,0);
        for (int i = 1; i <= 8; i++) v(1,1,32'(i),0, 0,0,4'(i),32'(i*(i+1)/2),0,0);
        v(1,1,100,1, 1,1,8,136,0,0);
        for (int i = 2; i <= 8; i++) v(1,0,0,1, 1,32'(i),4'(9-i),136,0,0);
        v(1,0,0,1, 1,100,0,136,0,0);
        v(1,0,0,1, 0,100,0,136,0,1);

        // Empty with simultaneous write and read: no bypass.
        v(0,0,0,0, 0,0,0,0,0,0);
        v(1,1,5,1, 0,0,1,5,0,1);
        v(1,0,0,1, 1,5,0,5,0,1);

        // Sum wraps modulo 2^32.
        v(0,0,0,0, 0,0,0,0,0,0);
        v(1,1,32'hFFFF_FFFF,0, 0,0,1,32'hFFFF_FFFF,0,0);
        v(1,1,2,0, 0,0,2,1,0,0);
        v(1,0,0,1, 1,32'hFFFF_FFFF,1,1,0,0);
        v(1,0,0,1, 1,2,0,1,0,0);

        // Reset with count=5 and a read in flight clears everything.
        v(0,0,0,0, 0,0,0,0,0,0);
        v(1,0,0,1, 0,0,0,0,0,1);
        for (int i = 1; i <= 5; i++) v(1,1,32'(i),0, 0,0,4'(i),32'(i*(i+1)/2),0,1);
        v(0,1,77,1, 0,0,0,0,0,0);
        v(1,0,0,0, 0,0,0,0,0,0);

        foreach (vecs[k]) begin
            drive_step(vecs[k].rst_n, vecs[k].in_valid, vecs[k].in_data, vecs[k].rd_req);
            check_all(k, vecs[k].exp_rv, vecs[k].exp_rd, vecs[k].exp_cnt,
                      vecs[k].exp_sum, vecs[k].exp_ovf, vecs[k].exp_unf);
        end

        // Interleaved writes and reads over 20 cycles; pointers wrap repeatedly.
        drive_step(1'b0, 1'b0, '0, 1'b0);
        exp_sum = '0;
        last_rd = '0;
        for (int i = 0; i < 20; i++) begin
            rr = (i >= 2) && (i % 5 != 0);
            exp_rv = 1'b0;
            if (rr && model_q.size() > 0) begin
                last_rd = model_q.pop_front();
                exp_rv  = 1'b1;
            end
            model_q.push_back(32'(200 + i));
            exp_sum = exp_sum + 32'(200 + i);
            drive_step(1'b1, 1'b1, 32'(200 + i), rr);
            check_all(1000 + i, exp_rv, last_rd, 4'(model_q.size()), exp_sum, 1'b0, 1'b0);
        end

        // Drain what remains and confirm order through the wrap.
        while (model_q.size() > 0) begin
            last_rd = model_q.pop_front();
            drive_step(1'b1, 1'b0, '0, 1'b1);
            check_all(2000 + model_q.size(), 1'b1, last_rd, 4'(model_q.size()),
                      exp_sum, 1'b0, 1'b0);
        end
        drive_step(1'b1, 1'b0, '0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
